// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue auto tester.
// Holds the tester state encoding, kv packing helper and LFSR tap table.
package pq_pkg;

  localparam int KW_DEF = 4;
  localparam int VW_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    MIX   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } tester_state_t;

  // Right-shift Galois masks giving maximal-length sequences
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    unique case (w)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0E08;
      13:      t = 32'h0000_1C80;
      14:      t = 32'h0000_3802;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_B400;
      default: t = 32'h0000_00B8;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] kv_pack(
    input logic [31:0] k,
    input logic [31:0] v,
    input int          vw
  );
    return (k << vw) | v;
  endfunction

endpackage

// File: rtl/pq_auto_tester_if.sv
// Tester <-> priority-queue bus: strobes, entry in/out and queue status.
// master = tester side, slave = queue side.
interface pq_auto_tester_if
  import pq_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int VW = VW_DEF
) ();

  logic              pq_full;
  logic              pq_empty;
  logic              pq_busy;
  logic [KW+VW-1:0]  pq_kvo;
  logic              pq_enq;
  logic              pq_deq;
  logic [KW+VW-1:0]  pq_kvi;

  modport master (
    input  pq_full, pq_empty, pq_busy, pq_kvo,
    output pq_enq, pq_deq, pq_kvi
  );

  modport slave (
    output pq_full, pq_empty, pq_busy, pq_kvo,
    input  pq_enq, pq_deq, pq_kvi
  );

endinterface

// File: rtl/pq_lfsr.sv
// Galois LFSR key/value generator; steps once per enb.
// Taps come from the shared table so any supported width is maximal.
module pq_lfsr
  import pq_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] SEED = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enb,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (enb) begin
      q_d = q_q[0] ? ((q_q >> 1) ^ TAPS) : (q_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= SEED;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pq_auto_tester.sv
// Self-checking traffic generator/checker for a min-priority queue.
// Define AUTO_PQ_LOOP_EN to restart passing runs automatically.
module pq_auto_tester
  import pq_pkg::*;
#(
  parameter int                KW      = KW_DEF,
  parameter int                VW      = VW_DEF,
  parameter int                N_ITEMS = 8,
  parameter int                LFSR_W  = 8,
  parameter logic [LFSR_W-1:0] SEED    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  pq_auto_tester_if.master     pq,
  output logic [KW+VW-1:0]     last_kv,
  output logic [7:0]           err_count,
  output logic [2:0]           state_o,
  output logic                 done,
  output logic                 pass
);

  localparam int KVW = KW + VW;
  localparam int CW  = $clog2(N_ITEMS + 1);
  localparam logic [CW-1:0] N_C = CW'(N_ITEMS);

  tester_state_t state_q, state_d;
  logic          mode_q, mode_d;
  logic          start_q;
  logic [CW-1:0] enq_cnt_q, enq_cnt_d;
  logic [CW-1:0] deq_cnt_q, deq_cnt_d;
  logic [7:0]    err_q, err_d;
  logic [KW-1:0] prev_key_q, prev_key_d;
  logic          has_prev_q, has_prev_d;
  logic          hold_q, hold_d;
  logic [KVW-1:0] last_kv_q, last_kv_d;
`ifdef AUTO_PQ_LOOP_EN
  logic          loop_q, loop_d;
`endif

  logic [LFSR_W-1:0] lfsr_q;
  logic              enq;
  logic              deq;
  logic              err_inc;
  logic              launch;
  logic              launch_mode;
  logic              slot;
  logic              start_rise;
  logic [KW-1:0]     kvo_key;

  pq_lfsr #(
    .W    (LFSR_W),
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .enb (enq),
    .q   (lfsr_q)
  );

  // A strobe is always followed by one dead cycle, then busy must clear
  assign slot       = !hold_q && !pq.pq_busy;
  assign start_rise = start && !start_q;
  assign kvo_key    = pq.pq_kvo[KVW-1 -: KW];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    enq_cnt_d   = enq_cnt_q;
    deq_cnt_d   = deq_cnt_q;
    err_d       = err_q;
    prev_key_d  = prev_key_q;
    has_prev_d  = has_prev_q;
    last_kv_d   = last_kv_q;
`ifdef AUTO_PQ_LOOP_EN
    loop_d      = loop_q;
`endif
    enq         = 1'b0;
    deq         = 1'b0;
    err_inc     = 1'b0;
    launch      = 1'b0;
    launch_mode = mode;

    unique case (state_q)
      IDLE: begin
        launch = start_rise;
      end
      FILL: begin
        if (enq_cnt_q == N_C) begin
          state_d = DRAIN;
        end else if (slot) begin
          if (pq.pq_full) begin
            err_inc = 1'b1;
            state_d = DRAIN;
          end else begin
            enq = 1'b1;
          end
        end
      end
      MIX: begin
        if (enq_cnt_q == N_C) begin
          state_d = DRAIN;
        end else if (slot) begin
          if (pq.pq_empty) begin
            enq     = 1'b1;
            err_inc = deq_cnt_q < enq_cnt_q;
          end else if (pq.pq_full || !lfsr_q[0]) begin
            deq = 1'b1;
          end else begin
            enq = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (slot) begin
          if (pq.pq_empty) begin
            err_inc = deq_cnt_q != enq_cnt_q;
            state_d = DONE;
          end else if (deq_cnt_q == enq_cnt_q) begin
            err_inc = 1'b1;
            state_d = DONE;
          end else begin
            deq = 1'b1;
          end
        end
      end
      DONE: begin
`ifdef AUTO_PQ_LOOP_EN
        if (start_rise) begin
          launch = 1'b1;
        end else if (err_q == 8'd0) begin
          if (loop_q) begin
            launch      = 1'b1;
            launch_mode = mode_q;
          end else begin
            loop_d = 1'b1;
          end
        end
`else
        launch = start_rise;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (enq) enq_cnt_d = enq_cnt_q + 1'b1;

    // Ordering only spans a contiguous non-empty window
    if (deq) begin
      deq_cnt_d  = deq_cnt_q + 1'b1;
      last_kv_d  = pq.pq_kvo;
      prev_key_d = kvo_key;
      has_prev_d = 1'b1;
      if (has_prev_q && (kvo_key < prev_key_q)) err_inc = 1'b1;
    end else if (pq.pq_empty) begin
      has_prev_d = 1'b0;
    end

    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    if (launch) begin
      mode_d     = launch_mode;
      state_d    = launch_mode ? MIX : FILL;
      enq_cnt_d  = '0;
      deq_cnt_d  = '0;
      err_d      = 8'd0;
      prev_key_d = '0;
      has_prev_d = 1'b0;
`ifdef AUTO_PQ_LOOP_EN
      loop_d     = 1'b0;
`endif
    end

    hold_d = enq | deq;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      start_q    <= 1'b0;
      enq_cnt_q  <= '0;
      deq_cnt_q  <= '0;
      err_q      <= 8'd0;
      prev_key_q <= '0;
      has_prev_q <= 1'b0;
      hold_q     <= 1'b0;
      last_kv_q  <= '0;
`ifdef AUTO_PQ_LOOP_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      start_q    <= start;
      enq_cnt_q  <= enq_cnt_d;
      deq_cnt_q  <= deq_cnt_d;
      err_q      <= err_d;
      prev_key_q <= prev_key_d;
      has_prev_q <= has_prev_d;
      hold_q     <= hold_d;
      last_kv_q  <= last_kv_d;
`ifdef AUTO_PQ_LOOP_EN
      loop_q     <= loop_d;
`endif
    end
  end

  assign pq.pq_enq = enq;
  assign pq.pq_deq = deq;
  assign pq.pq_kvi = KVW'(kv_pack(32'(lfsr_q[KW-1:0]),
                                  32'(lfsr_q[LFSR_W-1 -: VW]), VW));
  assign last_kv   = last_kv_q;
  assign err_count = err_q;
  assign state_o   = state_q;
  assign done      = state_q == DONE;
  assign pass      = (state_q == DONE) && (err_q == 8'd0);

endmodule

// File: tb/tb_pq_auto_tester.sv
// Bench for pq_auto_tester: behavioural PQ model plus run-level reference.
// Randomised modes/busy lengths; define AUTO_PQ_LOOP_EN to test the auto loop.
module tb_pq_auto_tester;

  localparam int N = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] last_kv;
  logic [7:0] err_count;
  logic [2:0] state_o;
  logic       done;
  logic       pass;

  pq_auto_tester_if #(.KW(4), .VW(4)) pq ();

  pq_auto_tester #(
    .KW(4), .VW(4), .N_ITEMS(N), .LFSR_W(8), .SEED(SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .pq        (pq),
    .last_kv   (last_kv),
    .err_count (err_count),
    .state_o   (state_o),
    .done      (done),
    .pass      (pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] kv_of(input logic [7:0] l);
    return {l[3:0], l[7:4]};
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
  endfunction

  // ---------------- behavioural priority queue ----------------
  int         cfg_busy = 0;
  int         cfg_cap = 16;
  bit         cfg_corrupt = 1'b0;
  int         mdeq = 0;
  int         bcnt = 0;
  logic [7:0] mq[$];
  logic [7:0] m_kvo;
  int         script[8] = '{3, 5, 2, 6, 7, 8, 9, 10};

  function automatic int min_idx();
    int b = 0;
    for (int i = 1; i < mq.size(); i++)
      if (mq[i][7:4] < mq[b][7:4]) b = i;
    return b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      bcnt = 0;
      pq.pq_busy  <= 1'b0;
      pq.pq_full  <= 1'b0;
      pq.pq_empty <= 1'b1;
      pq.pq_kvo   <= 8'h00;
    end else begin
      if (pq.pq_enq) mq.push_back(pq.pq_kvi);
      if (pq.pq_deq && mq.size() > 0) begin
        mq.delete(min_idx());
        mdeq++;
      end
      if (pq.pq_enq || pq.pq_deq) bcnt = cfg_busy;
      else if (bcnt > 0) bcnt--;
      m_kvo = (mq.size() > 0) ? mq[min_idx()] : 8'h00;
      if (cfg_corrupt && mdeq < 8) m_kvo[7:4] = 4'(script[mdeq]);
      pq.pq_busy  <= bcnt > 0;
      pq.pq_full  <= mq.size() >= cfg_cap;
      pq.pq_empty <= mq.size() == 0;
      pq.pq_kvo   <= m_kvo;
    end
  end

  // ---------------- protocol monitor and logs ----------------
  logic [7:0] ref_l;
  bit         prev_strobe;
  logic [7:0] enq_log[$];
  logic [7:0] deq_log[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_l = SEED;
      prev_strobe = 1'b0;
    end else begin
      if (pq.pq_enq || pq.pq_deq)
        chk("handshake", {pq.pq_enq & pq.pq_deq, pq.pq_busy,
                          pq.pq_enq & pq.pq_full,
                          pq.pq_deq & pq.pq_empty, prev_strobe}, 0);
      if (pq.pq_enq) begin
        chk("kvi", pq.pq_kvi, kv_of(ref_l));
        enq_log.push_back(pq.pq_kvi);
        ref_l = lfsr_step(ref_l);
      end
      if (pq.pq_deq) deq_log.push_back(pq.pq_kvo);
      prev_strobe = pq.pq_enq || pq.pq_deq;
    end
  end

  // Fill-then-drain must emit exactly the enqueued keys in sorted order
  function automatic int order_mismatch();
    logic [3:0] a[$];
    int m = 0;
    foreach (enq_log[i]) a.push_back(enq_log[i][7:4]);
    a.sort();
    if (a.size() != deq_log.size()) return 1;
    foreach (a[i]) if (a[i] != deq_log[i][7:4]) m++;
    return m;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_run(input bit m, input int busy, input int cap,
                        input bit corrupt, input int exp_err,
                        input string tag);
    int n = 0;
    int exp_n;
    cfg_busy = busy;
    cfg_cap = cap;
    cfg_corrupt = corrupt;
    mdeq = 0;
    enq_log.delete();
    deq_log.delete();
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, n < 4000, 1);
    exp_n = (cap < N) ? cap : N;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err_count, exp_err);
    chk({tag, "_pass"}, pass, exp_err == 0);
    chk({tag, "_enqs"}, enq_log.size(), exp_n);
    chk({tag, "_deqs"}, deq_log.size(), exp_n);
    if (deq_log.size() > 0)
      chk({tag, "_last_kv"}, last_kv, deq_log[deq_log.size()-1]);
    if (!m && !corrupt)
      chk({tag, "_sorted"}, order_mismatch(), 0);
`ifdef AUTO_PQ_LOOP_EN
    pulse_reset();
`endif
  endtask

  initial begin
    int n;
    logic [7:0] log1[$];
    int same;
    #2 rst = 1'b0;
    #20 rst = 1'b1;
    @(negedge clk);
    chk("rst_state", state_o, 3'd0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_last_kv", last_kv, 0);
    chk("rst_strobes", {pq.pq_enq, pq.pq_deq}, 0);
    chk("rst_kvi", pq.pq_kvi, kv_of(SEED));

    do_run(1'b0, 0, 16, 1'b0, 0, "ideal0");
`ifndef AUTO_PQ_LOOP_EN
    repeat (5) @(negedge clk);
    chk("done_hold_state", state_o, 3'd4);
    chk("done_hold_pass", pass, 1);
`endif
    do_run(1'b0, 1, 16, 1'b1, 1, "order");
    do_run(1'b0, 0, 5, 1'b0, 1, "full");
    do_run(1'b1, 3, 16, 1'b0, 0, "mixbusy");

    // Asynchronous abort in the middle of a fill
    cfg_busy = 3;
    cfg_cap = 16;
    cfg_corrupt = 1'b0;
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_fill", state_o, 3'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", state_o, 3'd0);
    chk("arst_strobes", {pq.pq_enq, pq.pq_deq}, 0);
    chk("arst_flags", {done, pass}, 0);
    chk("arst_err", err_count, 0);
    chk("arst_last_kv", last_kv, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_kvi", pq.pq_kvi, kv_of(SEED));
    do_run(1'b0, 0, 16, 1'b0, 0, "post_rst");
    if (enq_log.size() > 0) chk("post_rst_first", enq_log[0], kv_of(SEED));
    else chk("post_rst_first", 32'hFFFF, kv_of(SEED));

    for (int r = 0; r < 6; r++) begin
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             16, 1'b0, 0, "rnd");
    end

`ifdef AUTO_PQ_LOOP_EN
    cfg_busy = 0;
    cfg_cap = 16;
    cfg_corrupt = 1'b0;
    enq_log.delete();
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("auto_run1", done, 1);
    log1 = enq_log;
    enq_log.delete();
    n = 0;
    while (state_o == 3'd4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("auto_gap", n, 2);
    chk("auto_state", state_o, 3'd1);
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("auto_run2", done, 1);
    same = (log1.size() == enq_log.size()) ? 1 : 0;
    if (same == 1)
      foreach (log1[i]) if (log1[i] != enq_log[i]) same = 0;
    chk("auto_new_seq", same, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
